// File: rtl/ifu_if.sv
// Signal bundle between the fetch unit and its neighbours: redirect from
// execute, the instruction memory request/response port, and the decoder
// handshake. The master side is the fetch unit itself.
interface ifu_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [INST_WIDTH-1:0] imem_rsp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  rsp_err;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, rsp_err
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, rsp_err
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit. Issues sequential fetch requests, keeps the
// returned words in an in-order queue of DEPTH entries, and hands them to
// the decoder. Entries between head and fill are filled, entries between
// fill and alloc are still waiting for memory. A redirect empties the queue
// and, if memory still owes responses for the old stream, parks in DRAIN
// until those responses have been swallowed.
module ifu #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h8000_0000),
    parameter int                    DEPTH      = 4
) (
    input logic   clk,
    input logic   rst,
    ifu_if.master bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RUN, DRAIN} fetchState_e;

    fetchState_e           state, stateNext;
    logic [ADDR_WIDTH-1:0] fetchPc, fetchPcNext;
    logic [PW-1:0]         headPtr, headPtrNext;
    logic [PW-1:0]         allocPtr, allocPtrNext;
    logic [PW-1:0]         fillPtr, fillPtrNext;
    logic [CW-1:0]         allocCnt, allocCntNext;
    logic [CW-1:0]         pendCnt, pendCntNext;
    logic [CW-1:0]         dropCnt, dropCntNext;
    logic [CW-1:0]         dropTotal;
    logic                  rspErr, rspErrNext;
    logic [ADDR_WIDTH-1:0] qPc   [DEPTH];
    logic [INST_WIDTH-1:0] qWord [DEPTH];
    logic                  instValid, popFire, reqValid, reqFire, fillFire;

    // Handshakes of this cycle; a pop frees a slot in time for a same-cycle request
    always_comb begin
        instValid = (allocCnt != pendCnt);
        popFire   = instValid && bus.inst_ready;
        reqValid  = rst && (state == RUN) && !bus.redirect_valid &&
                    ((allocCnt != FULL) || popFire);
        reqFire   = reqValid && bus.imem_req_ready;
    end

    // Next-state logic for the FSM, fetch PC, queue pointers and counters
    always_comb begin
        stateNext    = state;
        fetchPcNext  = fetchPc;
        headPtrNext  = headPtr;
        allocPtrNext = allocPtr;
        fillPtrNext  = fillPtr;
        allocCntNext = allocCnt;
        pendCntNext  = pendCnt;
        dropCntNext  = dropCnt;
        dropTotal    = '0;
        rspErrNext   = rspErr;
        fillFire     = 1'b0;

        if (bus.redirect_valid) begin
            fetchPcNext  = bus.redirect_pc & ~ADDR_WIDTH'(3);
            headPtrNext  = '0;
            allocPtrNext = '0;
            fillPtrNext  = '0;
            allocCntNext = '0;
            pendCntNext  = '0;
            dropTotal    = dropCnt + pendCnt;
            if (bus.imem_rsp_valid) begin
                if (dropTotal == '0) begin
                    rspErrNext = 1'b1;
                end else begin
                    dropTotal = dropTotal - CW'(1);
                end
            end
            dropCntNext = dropTotal;
            stateNext   = (dropTotal != '0) ? DRAIN : RUN;
        end else if (state == DRAIN) begin
            if (bus.imem_rsp_valid) begin
                if (dropCnt == '0) begin
                    rspErrNext = 1'b1;
                end else begin
                    dropCntNext = dropCnt - CW'(1);
                end
            end
            stateNext = (dropCntNext == '0) ? RUN : DRAIN;
        end else begin
            if (bus.imem_rsp_valid) begin
                if (pendCnt != '0) begin
                    fillFire    = 1'b1;
                    fillPtrNext = fillPtr + PW'(1);
                end else begin
                    rspErrNext = 1'b1;
                end
            end
            if (popFire) begin
                headPtrNext = headPtr + PW'(1);
            end
            if (reqFire) begin
                allocPtrNext = allocPtr + PW'(1);
                fetchPcNext  = fetchPc + ADDR_WIDTH'(4);
            end
            allocCntNext = allocCnt + CW'(reqFire) - CW'(popFire);
            pendCntNext  = pendCnt + CW'(reqFire) - CW'(fillFire);
        end
    end

    // Control registers; reset forgets everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            fetchPc  <= RESET_PC;
            headPtr  <= '0;
            allocPtr <= '0;
            fillPtr  <= '0;
            allocCnt <= '0;
            pendCnt  <= '0;
            dropCnt  <= '0;
            rspErr   <= 1'b0;
        end else begin
            state    <= stateNext;
            fetchPc  <= fetchPcNext;
            headPtr  <= headPtrNext;
            allocPtr <= allocPtrNext;
            fillPtr  <= fillPtrNext;
            allocCnt <= allocCntNext;
            pendCnt  <= pendCntNext;
            dropCnt  <= dropCntNext;
            rspErr   <= rspErrNext;
        end
    end

    // Queue payload: PC captured on request accept, word captured on fill
    always_ff @(posedge clk) begin
        if (reqFire) begin
            qPc[allocPtr] <= fetchPc;
        end
        if (fillFire) begin
            qWord[fillPtr] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_req_addr  = fetchPc;
    assign bus.inst_valid     = instValid;
    assign bus.inst           = qWord[headPtr];
    assign bus.inst_pc        = qPc[headPtr];
    assign bus.rsp_err        = rspErr;
endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: an in-order variable-latency memory model and a
// queue-level reference of the fetch stream, driven by directed scenarios
// followed by a randomized run.
module tb_ifu;
    localparam int          AW       = 64;
    localparam int          IW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } memReq_t;

    logic clk;
    logic rst;

    ifu_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

    ifu #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          cycle;
    int          lastDue;
    int unsigned readyPct;
    int unsigned reqReadyPct;
    int unsigned latMin;
    int unsigned latMax;
    int          latPlan[$];
    bit          redirNow;
    logic [63:0] redirTarget;

    memReq_t     memQ[$];
    logic [63:0] mq[$];
    int          mFilled;
    int          mDrop;
    bit          mErr;
    logic [63:0] mFetch;

    logic [63:0] obsReq[$];
    int          obsReqCyc[$];
    logic [63:0] obsPc[$];
    int          obsPcCyc[$];

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ a[63:32];
    endfunction

    function automatic logic [63:0] reqAt(input int i);
        if (i < obsReq.size()) return obsReq[i];
        return '1;
    endfunction

    function automatic int reqCycAt(input int i);
        if (i < obsReqCyc.size()) return obsReqCyc[i];
        return -1000;
    endfunction

    function automatic logic [63:0] pcAt(input int i);
        if (i < obsPc.size()) return obsPc[i];
        return '1;
    endfunction

    function automatic int pcCycAt(input int i);
        if (i < obsPcCyc.size()) return obsPcCyc[i];
        return -1000;
    endfunction

    task automatic clearObs();
        obsReq.delete();
        obsReqCyc.delete();
        obsPc.delete();
        obsPcCyc.delete();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hold reset for n cycles, checking quiet outputs, and clear the model
    task automatic applyReset(input int n);
        rst                = 1'b0;
        redirNow           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        mq.delete();
        mFilled = 0;
        mDrop   = 0;
        mErr    = 1'b0;
        mFetch  = RESET_PC;
        memQ.delete();
        lastDue = cycle;
        repeat (n) begin
            @(negedge clk);
            checkOutput("rstReqValid", 64'(bus.imem_req_valid), 64'd0);
            checkOutput("rstInstValid", 64'(bus.inst_valid), 64'd0);
            checkOutput("rstRspErr", 64'(bus.rsp_err), 64'd0);
            @(posedge clk);
            #1;
            cycle++;
        end
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance model
    task automatic applyStimulus();
        bit          rspV;
        bit          popF;
        bit          expReq;
        bit          reqF;
        int          total;
        int          lat;
        int          due;
        logic [63:0] tgt;

        bus.inst_ready     = ($urandom_range(99) < readyPct);
        bus.imem_req_ready = ($urandom_range(99) < reqReadyPct);
        bus.redirect_valid = redirNow;
        bus.redirect_pc    = redirTarget;
        rspV = (memQ.size() > 0) && (memQ[0].due <= cycle);
        bus.imem_rsp_valid = rspV;
        bus.imem_rsp_data  = rspV ? memWord(memQ[0].addr) : 32'($urandom);

        @(negedge clk);
        popF   = (mFilled > 0) && bus.inst_ready;
        expReq = (mDrop == 0) && !redirNow && ((mq.size() < DEPTH) || popF);
        reqF   = expReq && bus.imem_req_ready;

        checkOutput("reqValid", 64'(bus.imem_req_valid), 64'(expReq));
        if (expReq) checkOutput("reqAddr", bus.imem_req_addr, mFetch);
        checkOutput("instValid", 64'(bus.inst_valid), 64'(mFilled > 0));
        if (mFilled > 0) begin
            checkOutput("instPc", bus.inst_pc, mq[0]);
            checkOutput("inst", 64'(bus.inst), 64'(memWord(mq[0])));
        end
        checkOutput("rspErr", 64'(bus.rsp_err), 64'(mErr));

        if (bus.imem_req_valid && bus.imem_req_ready) begin
            obsReq.push_back(bus.imem_req_addr);
            obsReqCyc.push_back(cycle);
        end
        if (bus.inst_valid && bus.inst_ready) begin
            obsPc.push_back(bus.inst_pc);
            obsPcCyc.push_back(cycle);
        end

        if (rspV) void'(memQ.pop_front());

        if (redirNow) begin
            total = mDrop + (mq.size() - mFilled);
            if (rspV) begin
                if (total == 0) mErr = 1'b1;
                else total--;
            end
            mq.delete();
            mFilled = 0;
            mDrop   = total;
            tgt     = redirTarget;
            tgt[1:0] = 2'b00;
            mFetch  = tgt;
        end else if (mDrop > 0) begin
            if (rspV) mDrop--;
        end else begin
            if (rspV) begin
                if (mFilled < mq.size()) mFilled++;
                else mErr = 1'b1;
            end
            if (popF) begin
                void'(mq.pop_front());
                mFilled--;
            end
            if (reqF) begin
                if (latPlan.size() > 0) lat = latPlan.pop_front();
                else lat = int'($urandom_range(latMax, latMin));
                due = cycle + lat;
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                memQ.push_back('{addr: mFetch, due: due});
                mq.push_back(mFetch);
                mFetch = mFetch + 64'd4;
            end
        end

        @(posedge clk);
        #1;
        cycle++;
        redirNow = 1'b0;
    endtask

    initial begin
        int staleHits;
        checks      = 0;
        errors      = 0;
        cycle       = 0;
        lastDue     = 0;
        readyPct    = 100;
        reqReadyPct = 100;
        latMin      = 1;
        latMax      = 1;
        redirNow    = 1'b0;
        redirTarget = '0;

        $display("[TB] reset and streaming");
        applyReset(5);
        clearObs();
        repeat (14) applyStimulus();
        checkOutput("firstReqAddr", reqAt(0), RESET_PC);
        checkOutput("firstLatency", 64'(pcCycAt(0) - reqCycAt(0)), 64'd2);
        for (int i = 0; i < 8; i++) begin
            checkOutput("streamPc", pcAt(i), RESET_PC + 64'(4 * i));
            checkOutput("streamCycle", 64'(pcCycAt(i) - pcCycAt(0)), 64'(i));
        end

        $display("[TB] backpressure");
        applyReset(2);
        readyPct = 0;
        clearObs();
        repeat (10) applyStimulus();
        checkOutput("bpReqCount", 64'(obsReq.size()), 64'd4);
        checkOutput("bpReqStall", 64'(bus.imem_req_valid), 64'd0);
        readyPct = 100;
        repeat (8) applyStimulus();
        for (int i = 0; i < 4; i++) begin
            checkOutput("bpPc", pcAt(i), RESET_PC + 64'(4 * i));
        end
        checkOutput("bpResume", reqAt(4), RESET_PC + 64'h10);

        $display("[TB] redirect with two in flight");
        applyReset(2);
        latPlan.push_back(3);
        latPlan.push_back(3);
        clearObs();
        repeat (2) applyStimulus();
        redirNow    = 1'b1;
        redirTarget = 64'h8000_1003;
        applyStimulus();
        repeat (12) applyStimulus();
        checkOutput("redirReqAddr", reqAt(2), 64'h8000_1000);
        checkOutput("redirFirstPc", pcAt(0), 64'h8000_1000);
        checkOutput("redirReqGap", 64'(reqCycAt(2) - reqCycAt(1)), 64'd4);

        $display("[TB] redirect inside drain");
        applyReset(2);
        latPlan.push_back(3);
        latPlan.push_back(5);
        clearObs();
        repeat (2) applyStimulus();
        redirNow    = 1'b1;
        redirTarget = 64'h8000_1000;
        applyStimulus();
        applyStimulus();
        redirNow    = 1'b1;
        redirTarget = 64'h8000_2000;
        applyStimulus();
        repeat (12) applyStimulus();
        checkOutput("drainReqAddr", reqAt(2), 64'h8000_2000);
        checkOutput("drainFirstPc", pcAt(0), 64'h8000_2000);
        checkOutput("drainReqGap", 64'(reqCycAt(2) - reqCycAt(1)), 64'd6);
        staleHits = 0;
        foreach (obsPc[i]) if (obsPc[i] == 64'h8000_1000) staleHits++;
        checkOutput("drainNoStale", 64'(staleHits), 64'd0);

        $display("[TB] reset mid-flight and spurious response");
        applyReset(2);
        latPlan.push_back(3);
        latPlan.push_back(3);
        repeat (2) applyStimulus();
        applyReset(2);
        reqReadyPct = 0;
        memQ.push_back('{addr: RESET_PC + 64'h4, due: cycle});
        lastDue = cycle;
        clearObs();
        repeat (3) applyStimulus();
        checkOutput("spurErrSet", 64'(bus.rsp_err), 64'd1);
        reqReadyPct = 100;
        repeat (10) applyStimulus();
        checkOutput("spurRestartReq", reqAt(0), RESET_PC);
        checkOutput("spurRestartPc", pcAt(0), RESET_PC);
        checkOutput("spurRestartPc3", pcAt(3), RESET_PC + 64'hC);
        checkOutput("spurErrSticky", 64'(bus.rsp_err), 64'd1);

        $display("[TB] randomized run");
        latMin      = 1;
        latMax      = 4;
        readyPct    = 70;
        reqReadyPct = 75;
        applyReset(2);
        for (int i = 0; i < 2500; i++) begin
            redirNow    = ($urandom_range(99) < 4);
            redirTarget = {32'($urandom), 32'($urandom)};
            if (i == 1200) begin
                redirNow    = 1'b1;
                redirTarget = 64'hFFFF_FFFF_FFFF_FFF5;
            end
            if (i == 1800) applyReset(3);
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit placed directly upstream of the decoder. Generates sequential fetch addresses from the reset PC and requests instruction words from an in-order, variable-latency instruction memory port. Buffers returned words with their PCs in a small in-order queue and presents them to the decoder through a valid/ready handshake. Accepts a redirect (jump/branch target) from execute, and on a redirect flushes wrong-path work and discards any stale memory responses.

## Interface
- `RESET_PC`, 64'h8000_0000: first fetch address after reset.
- `ADDR_WIDTH`, 64: PC / address width.
- `INST_WIDTH`, 32: instruction word width.
- `DEPTH`, 4: queue entries (power of two, ≥2); also the maximum number of requests in flight.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  one-cycle redirect pulse from execute.
- `redirect_pc`  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as 0.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  ADDR_WIDTH  fetch address.
- `imem_rsp_valid`  in  1  response word valid, strictly in request order.
- `imem_rsp_data`  in  INST_WIDTH  response word.
- `inst_valid`  out  1  instruction available to decoder.
- `inst_ready`  in  1  decoder consumes instruction.
- `inst`  out  INST_WIDTH  instruction word.
- `inst_pc`  out  ADDR_WIDTH  PC of `inst`.
- `rsp_err`  out  1  sticky flag: response arrived with nothing outstanding.

## Operation
- State: `fetch_pc`, queue (pc, word, filled), head/alloc/fill pointers, `drop_cnt`, FSM {RUN, DRAIN}.
- Issue: `imem_req_valid` = (state==RUN) && (allocated entries < DEPTH) && !redirect_valid. `imem_req_addr` = `fetch_pc`.
- On accept (valid&&ready): allocate entry at the alloc pointer with pc=`fetch_pc`, filled=0, and set `fetch_pc` += 4 (wraps modulo 2^ADDR_WIDTH).
- Response in RUN: write the word into the oldest unfilled entry and set filled=1.
- Output: `inst_valid` = head entry allocated && filled; `inst`/`inst_pc` come from the head entry. On inst_valid&&inst_ready the head entry is freed.
- Free and allocate may occur in the same cycle (full entry count is preserved).
- Redirect (any state):
  - all queue entries are invalidated and `fetch_pc` = `redirect_pc`;
  - `drop_cnt` += number of allocated-but-unfilled entries, counted before this cycle's response;
  - a response in the same cycle belongs to the old stream and is discarded, decrementing that count;
  - a decoder handshake in the same cycle still completes.
- FSM transitions:
  - RUN→DRAIN when a redirect leaves `drop_cnt`>0.
  - In DRAIN, each response is discarded and decrements `drop_cnt`. DRAIN→RUN on the edge where `drop_cnt` reaches 0.
  - A redirect in DRAIN updates `fetch_pc` and stays in DRAIN; no requests issue in DRAIN.
- Spurious response (RUN with no unfilled entry, or DRAIN with `drop_cnt`==0): the response is ignored and `rsp_err` is set; it is cleared only by reset.
- The memory tolerates `imem_req_valid` dropping without acceptance only in a redirect cycle. In all other cycles, valid and addr are held until accepted.

## Timing
- Reset (rst=0, asynchronous):
  - `fetch_pc`=RESET_PC, queue empty, `drop_cnt`=0, state=RUN, `rsp_err`=0;
  - `imem_req_valid`=0 and `inst_valid`=0 while rst=0;
  - in-flight requests are forgotten, and later responses count as spurious.
- First request is asserted in the first cycle with rst=1.
- Latency:
  - request accepted at edge N; response earliest in cycle N+1;
  - `inst_valid` is registered and rises in the cycle after the response is sampled;
  - minimum accept-to-`inst_valid` is 2 cycles.
- Throughput: one instruction per cycle with 1-cycle memory and `inst_ready`=1, for any DEPTH≥2.
- Full queue (DEPTH allocated): `imem_req_valid`=0 until an entry frees; a request may issue in the same cycle the free occurs.
- First request to a redirect target:
  - cycle after redirect if no responses are pending;
  - otherwise the cycle after `drop_cnt` reaches 0.

## Test plan
- Reset: hold rst=0 five cycles, verifying req_valid=0 and inst_valid=0. Release with 1-cycle memory → first imem_req_addr=0x8000_0000, inst_valid rises 2 cycles after first accept.
- Streaming: 1-cycle memory, inst_ready=1, 8 words → inst_pc 0x8000_0000…0x8000_001C on consecutive cycles, no bubbles.
- Backpressure: DEPTH=4, inst_ready=0 for 10 cycles → exactly 4 requests accepted, then req_valid=0. Raise ready → 4 instructions in order, fetch resumes at 0x8000_0010.
- Redirect with 2 in flight: 3-cycle memory, redirect to 0x8000_1000 → DRAIN, both old responses dropped, next req_addr=0x8000_1000, first inst_pc=0x8000_1000.
- Redirect inside DRAIN: second redirect to 0x8000_2000 while drop_cnt=1 → no new issue until drop, next req_addr=0x8000_2000, no 0x8000_1000 instruction delivered.
- Reset mid-flight and spurious response: assert rst with 2 outstanding, then deliver 1 response after release → rsp_err=1 and stays 1; fetch stream restarts at 0x8000_0000 unaffected.
